ov7670_pattern_gen: RTL and testbench

Synthetic OV7670 pixel-stream transmitter that drives the same PCLK/VSYNC/HREF/D[7:0] signalling the capture path consumes, emitting RGB444 pixels (xR GB byte order) at VGA camera timing. Lets the capture → frame buffer → VGA chain be exercised on-board and in simulation without a sensor. It sits in place of the OV7670 pins at the capture module's inputs and runs from the 50 MHz system clock.

---
 rtl/ov7670_pattern_gen.sv | 207 ++++++++++++++++++++
 tb/tb_ov7670_pattern_gen.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module  : ov7670_pattern_gen
// Brief   : Synthetic OV7670 RGB444 byte stream (PCLK/VSYNC/HREF/D) at camera
//           timing. Optional macro OV7670_PATGEN_SCROLL_EN scrolls the pattern.
// Rev     : 1.0
// ============================================================================
module ov7670_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 144,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 17,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [11:0] solid_color,
    output logic        pclk,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  d,
    output logic        frame_done,
    output logic [15:0] frame_count
);
    localparam int BYTES_PER_LINE = 2 * (H_ACTIVE + H_BLANK);
    localparam int V_TOTAL        = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int BCNT_W         = $clog2(BYTES_PER_LINE);
    localparam int LCNT_W         = $clog2(V_TOTAL);
    localparam int BAR_W          = H_ACTIVE / 8;

    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BYTES_PER_LINE - 1);
    localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);
    localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(V_TOTAL - 1);
    localparam logic [LCNT_W-1:0] LCNT_ONE  = LCNT_W'(1);

    localparam logic [31:0] C_ACT_FIRST = 32'(V_SYNC + V_BACK);
    localparam logic [31:0] C_ACT_END   = 32'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [31:0] C_HREF_END  = 32'(2 * H_ACTIVE);
    localparam logic [31:0] C_VSYNC_END = 32'(V_SYNC);
    localparam logic [31:0] C_H_ACTIVE  = 32'(H_ACTIVE);
    localparam logic [31:0] C_BAR_W     = 32'(BAR_W);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                pclk_q;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
    logic [1:0]          mode_q, mode_d;
    logic [11:0]         solid_q, solid_d;
    logic [15:0]         fcnt_q, fcnt_d;
    logic                done_q, done_d;
    logic                vsync_q, vsync_d;
    logic                href_q, href_d;
    logic [7:0]          data_q, data_d;

    logic                frame_start;
    logic                line_last;
    logic                frame_last;

    assign line_last  = (bcnt_q == BCNT_LAST);
    assign frame_last = line_last && (lcnt_q == LCNT_LAST);

    // Everything advances only at a slot boundary, i.e. the edge where pclk falls.
    always_comb begin
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        lcnt_d      = lcnt_q;
        mode_d      = mode_q;
        solid_d     = solid_q;
        fcnt_d      = fcnt_q;
        done_d      = 1'b0;
        frame_start = 1'b0;
        if (pclk_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_d     = ST_RUN;
                        frame_start = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (frame_last) begin
                        done_d = 1'b1;
                        fcnt_d = fcnt_q + 16'd1;
                        if (enable) begin
                            frame_start = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            bcnt_d  = '0;
                            lcnt_d  = '0;
                        end
                    end else if (line_last) begin
                        bcnt_d = '0;
                        lcnt_d = lcnt_q + LCNT_ONE;
                    end else begin
                        bcnt_d = bcnt_q + BCNT_ONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (frame_start) begin
                bcnt_d  = '0;
                lcnt_d  = '0;
                mode_d  = mode;
                solid_d = solid_color;
            end
        end
    end

    logic [31:0] b32;
    logic [31:0] l32;
    logic [31:0] xpix;
    logic [31:0] xs;
    logic        y5;
    logic [2:0]  bar;
    logic [11:0] rgb;
    logic        act;

    // Byte for the slot about to start, derived from the next counter values.
    always_comb begin
        b32  = 32'(bcnt_d);
        l32  = 32'(lcnt_d);
        xpix = b32 >> 1;
`ifdef OV7670_PATGEN_SCROLL_EN
        xs = xpix + (32'(fcnt_q) % C_H_ACTIVE);
        if (xs >= C_H_ACTIVE) begin
            xs = xs - C_H_ACTIVE;
        end
`else
        xs = xpix;
`endif
        y5  = 1'((l32 - C_ACT_FIRST) >> 5);
        bar = 3'(xs / C_BAR_W);
        rgb = 12'h000;
        case (mode_d)
            2'd0: begin
                case (bar)
                    3'd0: rgb = 12'hFFF;
                    3'd1: rgb = 12'hFF0;
                    3'd2: rgb = 12'h0FF;
                    3'd3: rgb = 12'h0F0;
                    3'd4: rgb = 12'hF0F;
                    3'd5: rgb = 12'hF00;
                    3'd6: rgb = 12'h00F;
                    default: rgb = 12'h000;
                endcase
            end
            2'd1:    rgb = {3{4'(xs >> 2)}};
            2'd2:    rgb = (1'(xs >> 5) ^ y5) ? 12'hFFF : 12'h000;
            default: rgb = solid_d;
        endcase
        act = (state_d == ST_RUN) && (l32 >= C_ACT_FIRST) && (l32 < C_ACT_END)
              && (b32 < C_HREF_END);
        vsync_d = (state_d == ST_RUN) && (l32 < C_VSYNC_END);
        href_d  = act;
        data_d  = 8'h00;
        if (act) begin
            data_d = bcnt_d[0] ? rgb[7:0] : {4'h0, rgb[11:8]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pclk_q  <= 1'b0;
            bcnt_q  <= '0;
            lcnt_q  <= '0;
            mode_q  <= 2'd0;
            solid_q <= 12'h000;
            fcnt_q  <= 16'd0;
            done_q  <= 1'b0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            pclk_q  <= ~pclk_q;
            bcnt_q  <= bcnt_d;
            lcnt_q  <= lcnt_d;
            mode_q  <= mode_d;
            solid_q <= solid_d;
            fcnt_q  <= fcnt_d;
            done_q  <= done_d;
            if (pclk_q) begin
                vsync_q <= vsync_d;
                href_q  <= href_d;
                data_q  <= data_d;
            end
        end
    end

    assign pclk        = pclk_q;
    assign vsync       = vsync_q;
    assign href        = href_q;
    assign d           = data_q;
    assign frame_done  = done_q;
    assign frame_count = fcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ov7670_pattern_gen.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for ov7670_pattern_gen: random mode/colour/enable stimulus checked every
// clk against a frame-timeline model built from the pixel rules.
module tb_ov7670_pattern_gen;
    localparam int HA  = 8;
    localparam int HB  = 4;
    localparam int VS  = 1;
    localparam int VB  = 1;
    localparam int VA  = 4;
    localparam int VF  = 1;
    localparam int BPL = 2 * (HA + HB);
    localparam int LPF = VS + VB + VA + VF;
    localparam int SPF = BPL * LPF;
    localparam int CPF = 2 * SPF;
`ifdef OV7670_PATGEN_SCROLL_EN
    localparam int SCROLL = 1;
`else
    localparam int SCROLL = 0;
`endif

    localparam logic [11:0] BARS [0:7] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                           12'hF0F, 12'hF00, 12'h00F, 12'h000};
    localparam logic [7:0] FIRST6 [0:5] = '{8'h0F, 8'hFF, 8'h0F, 8'hF0, 8'h00, 8'hFF};

    typedef struct packed {
        logic        pclk;
        logic        vsync;
        logic        href;
        logic [7:0]  d;
        logic        done;
        logic [15:0] fc;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [11:0] solid_color = 12'h000;
    logic        pclk;
    logic        vsync;
    logic        href;
    logic [7:0]  d;
    logic        frame_done;
    logic [15:0] frame_count;

    int errors = 0;
    int checks = 0;
    int k = 0;
    int nfr = 1000;
    logic [1:0]  fm [0:15];
    logic [11:0] fs [0:15];

    ov7670_pattern_gen #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .solid_color(solid_color),
        .pclk(pclk), .vsync(vsync), .href(href), .d(d),
        .frame_done(frame_done), .frame_count(frame_count)
    );

    always #10 clk = ~clk;

    function automatic logic [11:0] pix_rgb(int x, int y, logic [1:0] m, logic [11:0] sc, int f);
        int xs;
        logic [5:0] xb;
        logic [5:0] yb;
        xs = (SCROLL != 0) ? (x + f) % HA : x;
        xb = 6'(xs);
        yb = 6'(y);
        case (m)
            2'd0:    return BARS[xs / (HA / 8)];
            2'd1:    return {xb[5:2], xb[5:2], xb[5:2]};
            2'd2:    return (xb[5] ^ yb[5]) ? 12'hFFF : 12'h000;
            default: return sc;
        endcase
    endfunction

    // Expected outputs after the kk-th rising edge since reset release.
    function automatic obs_t exp_at(int kk);
        obs_t e;
        int s, f, p, line, b;
        logic [11:0] rgb;
        e = '0;
        e.pclk = kk[0];
        if (kk < 2) return e;
        s = (kk - 2) / 2;
        f = s / SPF;
        p = s % SPF;
        if (f >= nfr) begin
            e.fc   = 16'(nfr);
            e.done = (kk == 2 + CPF * nfr);
            return e;
        end
        e.fc    = 16'(f);
        e.done  = (f > 0) && ((kk - 2) % CPF == 0);
        line    = p / BPL;
        b       = p % BPL;
        e.vsync = (line < VS);
        e.href  = (line >= VS + VB) && (line < VS + VB + VA) && (b < 2 * HA);
        if (e.href) begin
            rgb = pix_rgb(b / 2, line - VS - VB, fm[f], fs[f], f);
            e.d = (b % 2 == 0) ? {4'h0, rgb[11:8]} : rgb[7:0];
        end
        return e;
    endfunction

    function automatic obs_t observe();
        return {pclk, vsync, href, d, frame_done, frame_count};
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("pclk=%b vsync=%b href=%b d=%h done=%b fc=%0d",
                         o.pclk, o.vsync, o.href, o.d, o.done, o.fc);
    endfunction

    task automatic step();
        @(posedge clk);
        k++;
        if (k >= 2 && (k - 2) % CPF == 0 && (k - 2) / CPF < 16) begin
            fm[(k - 2) / CPF] = mode;
            fs[(k - 2) / CPF] = solid_color;
        end
        @(negedge clk);
    endtask

    task automatic restart(logic en);
        reset  = 1'b1;
        enable = en;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        k     = 0;
    endtask

    task automatic test_reset();
        obs_t o;
        reset  = 1'b1;
        enable = 1'b1;
        mode   = 2'($urandom_range(0, 3));
        repeat (4) begin
            step();
            o = observe();
            checks++;
            if (o !== '0) begin
                errors++;
                $display("FAIL reset_state got %s want all zero", fmt(o));
            end
        end
    endtask

    task automatic test_bars();
        obs_t o, e;
        int vs_cnt;
        int href_cnt [0:LPF-1];
        logic [7:0] cap [$];
        vs_cnt = 0;
        foreach (href_cnt[i]) href_cnt[i] = 0;
        mode = 2'd0;
        nfr  = 1000;
        restart(1'b1);
        for (int c = 0; c < CPF + 4; c++) begin
            step();
            o = observe();
            e = exp_at(k);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL bars_timeline k=%0d got %s want %s", k, fmt(o), fmt(e));
            end
            if (k >= 2 && k < 2 + CPF) begin
                if (vsync) vs_cnt++;
                if (href) href_cnt[((k - 2) / 2) / BPL]++;
                if (href && pclk && ((k - 2) / 2) / BPL == 2) cap.push_back(d);
            end
        end
        checks++;
        if (vs_cnt !== 48) begin
            errors++;
            $display("FAIL vsync_width got=%0d want=48", vs_cnt);
        end
        for (int l = 0; l < LPF; l++) begin
            checks++;
            if (href_cnt[l] !== ((l >= 2 && l <= 5) ? 32 : 0)) begin
                errors++;
                $display("FAIL href_width line=%0d got=%0d want=%0d", l, href_cnt[l],
                         (l >= 2 && l <= 5) ? 32 : 0);
            end
        end
        checks++;
        if (cap.size() < 6) begin
            errors++;
            $display("FAIL bars_first_bytes got %0d bytes want at least 6", cap.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (cap[i] !== FIRST6[i]) begin
                    errors++;
                    $display("FAIL bars_byte%0d got=%h want=%h", i, cap[i], FIRST6[i]);
                end
            end
        end
    endtask

    task automatic test_solid();
        obs_t o, e;
        int nb;
        logic [7:0] want;
        nb          = 0;
        mode        = 2'd3;
        solid_color = 12'hA5C;
        nfr         = 1000;
        restart(1'b1);
        for (int c = 0; c < CPF + 4; c++) begin
            step();
            o = observe();
            e = exp_at(k);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL solid_timeline k=%0d got %s want %s", k, fmt(o), fmt(e));
            end
            if (href && pclk) begin
                want = (nb % 2 == 0) ? 8'h0A : 8'h5C;
                checks++;
                if (d !== want) begin
                    errors++;
                    $display("FAIL solid_byte n=%0d got=%h want=%h", nb, d, want);
                end
                nb++;
            end
        end
        checks++;
        if (nb !== 2 * HA * VA) begin
            errors++;
            $display("FAIL solid_byte_count got=%0d want=%0d", nb, 2 * HA * VA);
        end
    endtask

    task automatic test_mode_change();
        obs_t o, e;
        logic [11:0] sc;
        logic got_bar, got_solid;
        int line_idx;
        got_bar     = 1'b0;
        got_solid   = 1'b0;
        sc          = 12'($urandom);
        mode        = 2'd0;
        solid_color = ~sc;
        nfr         = 1000;
        restart(1'b1);
        for (int c = 0; c < 2 * CPF + 4; c++) begin
            if (k == 1 + 2 * 3 * BPL) begin
                mode        = 2'd3;
                solid_color = sc;
            end
            step();
            o = observe();
            e = exp_at(k);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL modechg_timeline k=%0d got %s want %s", k, fmt(o), fmt(e));
            end
            line_idx = (k >= 2) ? ((k - 2) / 2) / BPL : -1;
            if (href && pclk && line_idx == 4 && !got_bar) begin
                got_bar = 1'b1;
                checks++;
                if (d !== 8'h0F) begin
                    errors++;
                    $display("FAIL modechg_still_bars got=%h want=0f", d);
                end
            end
            if (href && pclk && line_idx == LPF + 2 && !got_solid) begin
                got_solid = 1'b1;
                checks++;
                if (d !== {4'h0, sc[11:8]}) begin
                    errors++;
                    $display("FAIL modechg_next_solid got=%h want=%h", d, {4'h0, sc[11:8]});
                end
            end
        end
        checks++;
        if (!(got_bar && got_solid)) begin
            errors++;
            $display("FAIL modechg_coverage got bar=%b solid=%b want 1/1", got_bar, got_solid);
        end
    endtask

    task automatic test_random_modes();
        obs_t o, e;
        mode        = 2'($urandom_range(0, 3));
        solid_color = 12'($urandom);
        nfr         = 1000;
        restart(1'b1);
        for (int c = 0; c < 3 * CPF + 4; c++) begin
            if ($urandom_range(0, 49) == 0) begin
                mode        = 2'($urandom_range(0, 3));
                solid_color = 12'($urandom);
            end
            step();
            o = observe();
            e = exp_at(k);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL random_timeline k=%0d got %s want %s", k, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_enable_drop();
        obs_t o, e;
        int drop, pulses;
        pulses      = 0;
        drop        = $urandom_range(3, CPF - 10);
        mode        = 2'($urandom_range(0, 3));
        solid_color = 12'($urandom);
        nfr         = 1;
        restart(1'b1);
        for (int c = 0; c < CPF + 122; c++) begin
            if (k == drop) enable = 1'b0;
            step();
            o = observe();
            e = exp_at(k);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL endrop_timeline k=%0d got %s want %s", k, fmt(o), fmt(e));
            end
            if (frame_done) pulses++;
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL endrop_done_pulses got=%0d want=1", pulses);
        end
        checks++;
        if (frame_count !== 16'd1) begin
            errors++;
            $display("FAIL endrop_frame_count got=%0d want=1", frame_count);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o, e;
        int target;
        target      = 2 + CPF + 2 * 4 * BPL + $urandom_range(0, 40);
        mode        = 2'($urandom_range(0, 3));
        solid_color = 12'($urandom);
        nfr         = 1000;
        restart(1'b1);
        while (k < target) begin
            step();
            o = observe();
            e = exp_at(k);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rstmid_pre k=%0d got %s want %s", k, fmt(o), fmt(e));
            end
        end
        reset = 1'b1;
        step();
        o = observe();
        checks++;
        if (o !== '0) begin
            errors++;
            $display("FAIL rstmid_abort got %s want all zero", fmt(o));
        end
        reset = 1'b0;
        k     = 0;
        for (int c = 0; c < CPF + 4; c++) begin
            step();
            o = observe();
            e = exp_at(k);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rstmid_post k=%0d got %s want %s", k, fmt(o), fmt(e));
            end
        end
    endtask

`ifdef OV7670_PATGEN_SCROLL_EN
    task automatic test_scroll();
        obs_t o, e;
        logic [7:0] cap [$];
        mode = 2'd0;
        nfr  = 1000;
        restart(1'b1);
        for (int c = 0; c < 2 * CPF + 4; c++) begin
            step();
            o = observe();
            e = exp_at(k);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL scroll_timeline k=%0d got %s want %s", k, fmt(o), fmt(e));
            end
            if (k >= 2 && href && pclk && ((k - 2) / 2) / BPL == LPF + 2) cap.push_back(d);
        end
        checks++;
        if (cap.size() < 2 || cap[0] !== 8'h0F || cap[1] !== 8'hF0) begin
            errors++;
            $display("FAIL scroll_frame1_x0 got=%h %h want=0f f0",
                     (cap.size() > 0) ? cap[0] : 8'hxx, (cap.size() > 1) ? cap[1] : 8'hxx);
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_bars();
        test_solid();
        test_mode_change();
        test_random_modes();
        test_enable_drop();
        test_reset_mid();
`ifdef OV7670_PATGEN_SCROLL_EN
        test_scroll();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
